// File: rtl/uart_cmd_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_wrapper
// Description : UART receiver that assembles 16-bit commands from byte pairs,
//               plus an independent UART transmitter for one-byte responses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_wrapper #(
    parameter int BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        trmt,
    input  logic [7:0]  resp,
    output logic        tx_done
);

    localparam int                 CNT_W   = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0]   HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0]   BIT_M1  = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic       {ASM_HIGH, ASM_LOW}                   asm_state_t;
    typedef enum logic       {TX_IDLE, TX_XMIT}                    tx_state_t;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]       rx_bits_q, rx_bits_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_rdy, start_ok;

    asm_state_t       asm_q, asm_d;
    logic [15:0]      cmd_q, cmd_d;
    logic             cmd_rdy_q, cmd_rdy_d;

    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]       tx_bits_q, tx_bits_d;
    logic [9:0]       tx_frame_q, tx_frame_d;
    logic             tx_done_q, tx_done_d;

    // Receive path: mid-bit sampling of the synchronized line.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bits_d  = rx_bits_q;
        rx_shift_d = rx_shift_q;
        rx_rdy     = 1'b0;
        start_ok   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_bits_d  = '0;
                        start_ok   = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bits_d  = rx_bits_q + 4'd1;
                    if (rx_bits_q == 4'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_M1) begin
                    rx_cnt_d   = '0;
                    rx_rdy     = 1'b1;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Command assembly; a completing byte outranks a simultaneous consume.
    always_comb begin
        asm_d     = asm_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        if (clr_cmd_rdy || (start_ok && asm_q == ASM_HIGH)) begin
            cmd_rdy_d = 1'b0;
        end
        if (rx_rdy) begin
            if (asm_q == ASM_HIGH) begin
                cmd_d[15:8] = rx_shift_q;
                asm_d       = ASM_LOW;
            end else begin
                cmd_d[7:0]  = rx_shift_q;
                asm_d       = ASM_HIGH;
                cmd_rdy_d   = 1'b1;
            end
        end
    end

    // Transmit path: TX is the LSB of a frame register that idles all-ones.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bits_d  = tx_bits_q;
        tx_frame_d = tx_frame_q;
        tx_done_d  = tx_done_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (trmt) begin
                    tx_frame_d = {1'b1, resp, 1'b0};
                    tx_done_d  = 1'b0;
                    tx_bits_d  = '0;
                    tx_state_d = TX_XMIT;
                end
            end
            TX_XMIT: begin
                if (tx_cnt_q == BIT_M1) begin
                    tx_cnt_d   = '0;
                    tx_frame_d = {1'b1, tx_frame_q[9:1]};
                    tx_bits_d  = tx_bits_q + 4'd1;
                    if (tx_bits_q == 4'd9) begin
                        tx_done_d  = 1'b1;
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bits_q  <= '0;
            rx_shift_q <= '0;
            asm_q      <= ASM_HIGH;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bits_q  <= '0;
            tx_frame_q <= '1;
            tx_done_q  <= 1'b0;
        end else begin
            rx_meta_q  <= RX;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bits_q  <= rx_bits_d;
            rx_shift_q <= rx_shift_d;
            asm_q      <= asm_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bits_q  <= tx_bits_d;
            tx_frame_q <= tx_frame_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign TX      = tx_frame_q[0];
    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign tx_done = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_wrapper
// Description : Self-checking bench: UART command pairs and response frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_wrapper;

    localparam int BD   = 434;
    localparam int HALF = BD / 2;

    localparam int PRE_NONE   = 0;
    localparam int PRE_GLITCH = 1;
    localparam int PRE_RESET  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        trmt = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        tx_done;

    int checks = 0;
    int errors = 0;

    // Model state: the command word the remote last completed.
    logic [15:0] model_cmd = 16'h0000;

    uart_cmd_wrapper #(.BAUD_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd),
        .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .trmt(trmt),
        .resp(resp), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         pre;
        logic [7:0] hi;
        logic [7:0] lo;
        bit         do_tx;
        logic [7:0] tx_byte;
        bit         second_trmt;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_window(input string nm, input int at);
        checks++;
        if (at < HALF - 1 || at > HALF + 5) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", nm, at, HALF - 1, HALF + 5);
        end
    endtask

    // Drives one UART frame; reports the first stop-bit cycle showing cmd_rdy.
    task automatic send_byte(input logic [7:0] b, input bit clr_stop, output int rdy_at);
        logic [9:0] fr;
        fr     = {1'b1, b, 1'b0};
        rdy_at = -1;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < BD; j++) begin
                @(negedge clk);
                RX = fr[i];
                if (i == 9) begin
                    clr_cmd_rdy = clr_stop;
                    if (cmd_rdy && rdy_at < 0) rdy_at = j;
                end
            end
        end
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] hi, input logic [7:0] lo, input bit clr_stop);
        int at;
        send_byte(hi, 1'b0, at);
        check("rdy_after_high", 32'(at), 32'hFFFF_FFFF);
        send_byte(lo, clr_stop, at);
        model_cmd = {hi, lo};
        check_window("rdy_window", at);
        check("cmd_value", 32'(cmd), 32'(model_cmd));
    endtask

    task automatic consume();
        @(negedge clk); clr_cmd_rdy = 1'b1;
        @(negedge clk); clr_cmd_rdy = 1'b0;
        check("rdy_after_clr", 32'(cmd_rdy), 32'd0);
        check("cmd_after_clr", 32'(cmd), 32'(model_cmd));
    endtask

    // Requests one response and checks every cycle of the line against {1,r,0}.
    task automatic tx_frame(input logic [7:0] r, input bit second);
        logic [9:0] fr;
        int bad;
        fr  = {1'b1, r, 1'b0};
        bad = 0;
        @(negedge clk); trmt = 1'b1; resp = r;
        @(negedge clk); trmt = 1'b0;
        check("tx_done_cleared", 32'(tx_done), 32'd0);
        for (int c = 0; c < 10 * BD; c++) begin
            if (TX !== fr[c / BD]) bad++;
            if (c == 10 * BD - 1) check("tx_done_early", 32'(tx_done), 32'd0);
            if (second && c == 1000) begin
                trmt = 1'b1; resp = ~r;
            end else begin
                trmt = 1'b0;
            end
            @(negedge clk);
        end
        check("tx_wave_bad_cycles", 32'(bad), 32'd0);
        check("tx_idle_after", 32'(TX), 32'd1);
        check("tx_done_set", 32'(tx_done), 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_TX", 32'(TX), 32'd1);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
    endtask

    initial begin
        logic [9:0] part;
        logic [7:0] c1h, c1l, c2h, c2l, rr;
        int at;

        vecs[0] = '{PRE_NONE,   8'h20, 8'h00, 1'b1, 8'hA5, 1'b1};
        vecs[1] = '{PRE_GLITCH, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{PRE_RESET,  8'hAB, 8'hCD, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{PRE_NONE,   8'h34, 8'h56, 1'b1, 8'hA5, 1'b0};
        vecs[4] = '{PRE_NONE,   8'($urandom), 8'($urandom), 1'b1, 8'($urandom), 1'b0};

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].pre == PRE_GLITCH) begin
                repeat (100) begin @(negedge clk); RX = 1'b0; end
                @(negedge clk); RX = 1'b1;
                repeat (400) @(negedge clk);
                check("glitch_rdy", 32'(cmd_rdy), 32'd0);
                check("glitch_cmd", 32'(cmd), 32'(model_cmd));
            end else if (vecs[v].pre == PRE_RESET) begin
                send_byte(8'h55, 1'b0, at);
                part = {1'b1, 8'h0F, 1'b0};
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < BD; j++) begin
                        @(negedge clk); RX = part[i];
                    end
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                model_cmd = 16'h0000;
                check_reset_outputs();
                RX = 1'b1;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (4) @(negedge clk);
                check("post_reset_rdy", 32'(cmd_rdy), 32'd0);
            end
            fork
                send_pair(vecs[v].hi, vecs[v].lo, 1'b0);
                if (vecs[v].do_tx) tx_frame(vecs[v].tx_byte, vecs[v].second_trmt);
            join
            check("rdy_held", 32'(cmd_rdy), 32'd1);
            consume();
            repeat (3) @(negedge clk);
        end

        // Two commands back to back with no idle gap; consume overlaps the
        // completion of the second one, which must still produce cmd_rdy.
        c1h = 8'($urandom); c1l = 8'($urandom);
        c2h = 8'($urandom); c2l = 8'($urandom);
        rr  = 8'($urandom);
        fork
            begin
                send_pair(c1h, c1l, 1'b0);
                send_byte(c2h, 1'b0, at);
                check("b2b_rdy_cleared_on_new_start", 32'(at), 32'hFFFF_FFFF);
                send_byte(c2l, 1'b1, at);
                model_cmd = {c2h, c2l};
                check_window("b2b_set_beats_clr", at);
                check("b2b_cmd", 32'(cmd), 32'(model_cmd));
                check("b2b_rdy_consumed", 32'(cmd_rdy), 32'd0);
            end
            tx_frame(rr, 1'b0);
        join

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_wrapper.md
UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

Interface
REQ-001 Parameter: BAUD_DIV, default 434, clocks per UART bit (115200 baud at 50 MHz).
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: RX  input  1  serial command line from the remote; idle high; asynchronous to clk.
REQ-005 Port: TX  output  1  serial response line to the remote; idle high.
REQ-006 Port: cmd  output  16  assembled command word; high byte received first.
REQ-007 Port: cmd_rdy  output  1  high while a complete, unconsumed command is held in cmd.
REQ-008 Port: clr_cmd_rdy  input  1  single-cycle consume pulse from the command processor.
REQ-009 Port: trmt  input  1  single-cycle request to transmit resp.
REQ-010 Port: resp  input  8  response byte, e.g. 0xA5 positive ack; sampled on trmt.
REQ-011 Port: tx_done  output  1  set when a response frame completes; cleared on the next accepted trmt.

Function
REQ-012 RX shall pass through two flops, reset high, before any use; all edge detection uses the synchronized value.
REQ-013 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit is BAUD_DIV clocks.
REQ-014 RX FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on a synchronized falling edge.
REQ-015 START: sample at BAUD_DIV/2 (integer divide).
- If RX is high there, treat the edge as a glitch and return to IDLE with no byte produced.
- Otherwise move to DATA.
REQ-016 DATA: sample each bit BAUD_DIV clocks after the previous sample and shift it in at the MSB, right-shifting; after 8 samples move to STOP.
REQ-017 STOP: sample once more BAUD_DIV clocks later, then return to IDLE.
- The stop value is not checked; the byte is accepted regardless.
- Acceptance raises an internal 1-cycle rx_rdy.
REQ-018 Byte assembly FSM states: HIGH, LOW.
- On rx_rdy in HIGH: latch the byte into cmd[15:8] and go to LOW.
- On rx_rdy in LOW: latch the byte into cmd[7:0], go to HIGH, and set cmd_rdy on the next clock edge.
REQ-019 cmd_rdy clear conditions:
- cleared on the cycle after clr_cmd_rdy;
- also cleared when a new start bit is validated in HIGH (new command begins).
- If clr_cmd_rdy and the set condition occur in the same cycle, set wins.
REQ-020 cmd shall hold its value until overwritten byte-by-byte by a later command; cmd is not cleared by clr_cmd_rdy.
REQ-021 TX FSM states: IDLE, XMIT.
- trmt in IDLE latches resp into a 10-bit frame {1, resp, 0}, clears tx_done, and enters XMIT.
- The first TX low (start bit) appears on the next cycle.
REQ-022 XMIT: shift the frame out LSB first, BAUD_DIV clocks per bit.
- After the 10th bit period ends, TX returns high, tx_done is set, and the FSM goes to IDLE.
- Frame length is exactly 10*BAUD_DIV clocks.
REQ-023 trmt while in XMIT shall be ignored; the current frame is not disturbed.
REQ-024 RX and TX paths shall operate fully concurrently and independently.
REQ-025 All baud counters shall be sized by $clog2(BAUD_DIV) and reset to zero on every state entry.

Reset
REQ-026 On rst_n low, immediately and asynchronously:
- TX=1, cmd=0x0000, cmd_rdy=0, tx_done=0;
- RX sync flops=1;
- both FSMs to IDLE; byte assembly to HIGH.
REQ-027 Reset asserted mid-frame shall abandon any partial byte or half-assembled command; no cmd_rdy results from it.
REQ-028 After rst_n deasserts, a frame whose start edge begins at least 2 clocks later shall be received correctly.

Verification
REQ-029 Calibrate command: drive bytes 0x20 then 0x00 on RX at BAUD_DIV=434.
- cmd=0x2000; cmd_rdy rises within 3 clocks of the second stop-bit sample.
REQ-030 Consume: pulse clr_cmd_rdy one cycle.
- cmd_rdy=0 next cycle; cmd still 0x2000.
REQ-031 Ack: pulse trmt with resp=0xA5.
- TX waveform 0,1,0,1,0,0,1,0,1,1, each bit 434 clocks.
- tx_done high at 4340 clocks; a second trmt at clock 1000 has no effect.
REQ-032 Glitch: drive RX low for 100 clocks, then high.
- No rx_rdy, no state change; a following 0x12,0x34 pair yields cmd=0x1234.
REQ-033 Reset mid-operation: assert rst_n after 0x55 plus 4 bits of a second byte.
- All outputs at reset values; the next full pair 0xAB,0xCD yields cmd=0xABCD.
REQ-034 Concurrency: transmit 0xA5 while receiving 0x3456 with overlapping frames.
- Both complete correctly; back-to-back commands with no idle gap both produce cmd_rdy.
